// File: rtl/mp_adder_pipe.sv
// ============================================================================
//  Module      : mp_adder_pipe
//  Description : Multi-precision add/subtract pipeline. Each stage adds one
//                SEG_WIDTH segment; the carry and the operand/sum segments
//                move through per-stage registers in a skewed arrangement.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mp_adder_pipe #(
    parameter int ADDER_WIDTH = 256,
    parameter int SEG_WIDTH   = 32
) (
    input  logic                   iClk,
    input  logic                   iRstn,
    input  logic                   iValid,
    output logic                   oReady,
    input  logic [ADDER_WIDTH-1:0] iA,
    input  logic [ADDER_WIDTH-1:0] iB,
    input  logic                   iC,
    input  logic                   iSub,
    output logic                   oValid,
    input  logic                   iReady,
    output logic [ADDER_WIDTH-1:0] oSum,
    output logic                   oC,
    output logic                   oOvf
);

    localparam int NUM_SEG = ADDER_WIDTH / SEG_WIDTH;
    localparam int LAST    = NUM_SEG - 1;

    logic                   advance;
    logic [ADDER_WIDTH-1:0] b_eff;

    assign b_eff = iSub ? ~iB : iB;

    genvar k;
    for (k = 0; k < NUM_SEG; k++) begin : g_stage
        localparam int LO  = k * SEG_WIDTH;
        localparam int REM = ADDER_WIDTH - LO;

        // a_in/b_in hold the segments not yet added; segment k is the low slice.
        logic [REM-1:0]          a_in;
        logic [REM-1:0]          b_in;
        logic                    c_in;
        logic                    v_in;
        logic [SEG_WIDTH:0]      seg_res;
        logic [LO+SEG_WIDTH-1:0] sum_nxt;
        logic [LO+SEG_WIDTH-1:0] sum_d;
        logic [LO+SEG_WIDTH-1:0] sum_q;
        logic                    carry_d;
        logic                    carry_q;
        logic                    vld_d;
        logic                    vld_q;

        if (k == 0) begin : g_head
            assign a_in    = iA;
            assign b_in    = b_eff;
            assign c_in    = iC;
            assign v_in    = iValid;
            assign sum_nxt = seg_res[SEG_WIDTH-1:0];
        end else begin : g_body
            assign a_in    = g_stage[k-1].g_mid.rem_a_q;
            assign b_in    = g_stage[k-1].g_mid.rem_b_q;
            assign c_in    = g_stage[k-1].carry_q;
            assign v_in    = g_stage[k-1].vld_q;
            assign sum_nxt = {seg_res[SEG_WIDTH-1:0], g_stage[k-1].sum_q};
        end

        // Single segment-wide add; the synthesis tool maps it to a fast adder.
        assign seg_res = {1'b0, a_in[SEG_WIDTH-1:0]}
                       + {1'b0, b_in[SEG_WIDTH-1:0]}
                       + {{SEG_WIDTH{1'b0}}, c_in};

        always_comb begin
            vld_d   = vld_q;
            carry_d = carry_q;
            sum_d   = sum_q;
            if (advance) begin
                vld_d   = v_in;
                carry_d = seg_res[SEG_WIDTH];
                sum_d   = sum_nxt;
            end
        end

        always_ff @(posedge iClk or negedge iRstn) begin
            if (!iRstn) begin
                vld_q   <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else begin
                vld_q   <= vld_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        if (k < LAST) begin : g_mid
            logic [REM-SEG_WIDTH-1:0] rem_a_d;
            logic [REM-SEG_WIDTH-1:0] rem_a_q;
            logic [REM-SEG_WIDTH-1:0] rem_b_d;
            logic [REM-SEG_WIDTH-1:0] rem_b_q;

            always_comb begin
                rem_a_d = rem_a_q;
                rem_b_d = rem_b_q;
                if (advance) begin
                    rem_a_d = a_in[REM-1:SEG_WIDTH];
                    rem_b_d = b_in[REM-1:SEG_WIDTH];
                end
            end

            always_ff @(posedge iClk) begin
                rem_a_q <= rem_a_d;
                rem_b_q <= rem_b_d;
            end
        end else begin : g_tail
            logic ovf_d;
            logic ovf_q;

            // The top segment still carries the operand MSBs, so overflow is decided here.
            always_comb begin
                ovf_d = ovf_q;
                if (advance) begin
                    ovf_d = (a_in[REM-1] == b_in[REM-1]) &&
                            (seg_res[SEG_WIDTH-1] != a_in[REM-1]);
                end
            end

            always_ff @(posedge iClk or negedge iRstn) begin
                if (!iRstn) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign oValid  = g_stage[LAST].vld_q;
    assign oSum    = g_stage[LAST].sum_q;
    assign oC      = g_stage[LAST].carry_q;
    assign oOvf    = g_stage[LAST].g_tail.ovf_q;
    assign advance = ~(oValid & ~iReady);
    assign oReady  = advance;

endmodule

`default_nettype wire

// File: tb/tb_mp_adder_pipe.sv
// ============================================================================
//  Module      : tb_mp_adder_pipe
//  Description : Self-checking bench for mp_adder_pipe against an arithmetic
//                reference model (main instance SEG_WIDTH=32, plus 8 and 256).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mp_adder_pipe;

    localparam int W   = 256;
    localparam int LAT = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;

    logic         rdy_32, vld_32, co_32, ovf_32;
    logic [W-1:0] sum_32;
    logic         rdy_8, vld_8, co_8, ovf_8;
    logic [W-1:0] sum_8;
    logic         rdy_256, vld_256, co_256, ovf_256;
    logic [W-1:0] sum_256;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t q32[$];
    res_t q8[$];
    res_t q256[$];

    always #5 clk = ~clk;

    mp_adder_pipe #(.ADDER_WIDTH(W), .SEG_WIDTH(32)) dut (
        .iClk(clk), .iRstn(rst_n), .iValid(in_valid), .oReady(rdy_32),
        .iA(a), .iB(b), .iC(cin), .iSub(sub), .oValid(vld_32), .iReady(in_ready),
        .oSum(sum_32), .oC(co_32), .oOvf(ovf_32)
    );

    mp_adder_pipe #(.ADDER_WIDTH(W), .SEG_WIDTH(8)) dut_s8 (
        .iClk(clk), .iRstn(rst_n), .iValid(in_valid), .oReady(rdy_8),
        .iA(a), .iB(b), .iC(cin), .iSub(sub), .oValid(vld_8), .iReady(in_ready),
        .oSum(sum_8), .oC(co_8), .oOvf(ovf_8)
    );

    mp_adder_pipe #(.ADDER_WIDTH(W), .SEG_WIDTH(256)) dut_s256 (
        .iClk(clk), .iRstn(rst_n), .iValid(in_valid), .oReady(rdy_256),
        .iA(a), .iB(b), .iC(cin), .iSub(sub), .oValid(vld_256), .iReady(in_ready),
        .oSum(sum_256), .oC(co_256), .oOvf(ovf_256)
    );

    // Reference: unsigned sum for the carry, sign-extended sum for overflow.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        logic [W-1:0] ye;
        logic [W:0]   u;
        logic [W+1:0] sg;
        res_t         r;
        ye    = s ? ~y : y;
        u     = {1'b0, x} + {1'b0, ye} + (W+1)'(c);
        sg    = {{2{x[W-1]}}, x} + {{2{ye[W-1]}}, ye} + (W+2)'(c);
        r.sum = u[W-1:0];
        r.c   = u[W];
        r.ovf = (sg[W+1:W-1] != 3'b000) && (sg[W+1:W-1] != 3'b111);
        return r;
    endfunction

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] v;
        for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
        case ($urandom_range(0, 7))
            0: v = '1;
            1: v = '0;
            2: v = {1'b1, {(W-1){1'b0}}};
            3: v = {1'b0, {(W-1){1'b1}}};
            default: ;
        endcase
        return v;
    endfunction

    task automatic drive(input logic v, input logic r);
        @(negedge clk);
        in_valid = v;
        in_ready = r;
        a        = rand256();
        b        = rand256();
        cin      = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_ready = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q32.delete();
        q8.delete();
        q256.delete();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        n_checks++; if (vld_32 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", vld_32); end
        n_checks++; if (sum_32 !== '0)   begin n_fail++; $display("FAIL reset_sum: got %h expected 0", sum_32); end
        n_checks++; if (co_32 !== 1'b0)  begin n_fail++; $display("FAIL reset_carry: got %b expected 0", co_32); end
        n_checks++; if (ovf_32 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf_32); end
        n_checks++; if (rdy_32 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", rdy_32); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (rdy_32 !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b expected 1", rdy_32); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ca[4], cb[4], es[4];
        logic         cc[4], cs[4], ec[4], eo[4];
        int           lat;
        res_t         got, exp;
        ca[0] = '1;                   cb[0] = '0;         cc[0] = 1; cs[0] = 0;
        es[0] = '0;                   ec[0] = 1; eo[0] = 0;
        ca[1] = W'(5);                cb[1] = W'(7);      cc[1] = 1; cs[1] = 1;
        es[1] = {{(W-1){1'b1}}, 1'b0}; ec[1] = 0; eo[1] = 0;
        ca[2] = W'(7);                cb[2] = W'(5);      cc[2] = 1; cs[2] = 1;
        es[2] = W'(2);                ec[2] = 1; eo[2] = 0;
        ca[3] = {1'b0, {(W-1){1'b1}}}; cb[3] = W'(1);     cc[3] = 0; cs[3] = 0;
        es[3] = {1'b1, {(W-1){1'b0}}}; ec[3] = 0; eo[3] = 1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            in_valid = 1'b1; in_ready = 1'b1;
            a = ca[t]; b = cb[t]; cin = cc[t]; sub = cs[t];
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            #1;
            while (!vld_32 && lat < 50) begin
                @(negedge clk);
                lat++;
                #1;
            end
            exp = '{sum: es[t], c: ec[t], ovf: eo[t]};
            got = '{sum: sum_32, c: co_32, ovf: ovf_32};
            n_checks++;
            if (lat != LAT) begin n_fail++; $display("FAIL directed%0d_latency: got %0d expected %0d", t, lat, LAT); end
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL directed%0d_result: got %h expected %h", t, got, exp); end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int   n_out, first, last;
        res_t e, got;
        apply_reset();
        n_out = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 140; cyc++) begin
            drive(cyc < 100, 1'b1);
            if (vld_32) begin
                got = '{sum: sum_32, c: co_32, ovf: ovf_32};
                n_checks++;
                if (q32.size() == 0) begin n_fail++; $display("FAIL b2b_s32_extra: got %h expected none", got); end
                else begin e = q32.pop_front(); if (got !== e) begin n_fail++; $display("FAIL b2b_s32: got %h expected %h", got, e); end end
                n_out++; if (first < 0) first = cyc; last = cyc;
            end
            if (vld_8) begin
                got = '{sum: sum_8, c: co_8, ovf: ovf_8};
                n_checks++;
                if (q8.size() == 0) begin n_fail++; $display("FAIL b2b_s8_extra: got %h expected none", got); end
                else begin e = q8.pop_front(); if (got !== e) begin n_fail++; $display("FAIL b2b_s8: got %h expected %h", got, e); end end
            end
            if (vld_256) begin
                got = '{sum: sum_256, c: co_256, ovf: ovf_256};
                n_checks++;
                if (q256.size() == 0) begin n_fail++; $display("FAIL b2b_s256_extra: got %h expected none", got); end
                else begin e = q256.pop_front(); if (got !== e) begin n_fail++; $display("FAIL b2b_s256: got %h expected %h", got, e); end end
            end
            e = model(a, b, cin, sub);
            if (in_valid && rdy_32)  q32.push_back(e);
            if (in_valid && rdy_8)   q8.push_back(e);
            if (in_valid && rdy_256) q256.push_back(e);
        end
        n_checks++; if (n_out != 100) begin n_fail++; $display("FAIL b2b_count: got %0d expected 100", n_out); end
        n_checks++; if (last - first != 99) begin n_fail++; $display("FAIL b2b_throughput: got span %0d expected 99", last - first); end
        n_checks++; if (q32.size() + q8.size() + q256.size() != 0) begin
            n_fail++; $display("FAIL b2b_drain: got %0d pending expected 0", q32.size() + q8.size() + q256.size()); end
    endtask

    task automatic test_bubbles_random();
        logic hold;
        res_t held, got, e;
        apply_reset();
        hold = 1'b0; held = '0;
        for (int cyc = 0; cyc < 320; cyc++) begin
            if (cyc < 300) drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            else           drive(1'b0, 1'b1);
            got = '{sum: sum_32, c: co_32, ovf: ovf_32};
            if (hold) begin
                n_checks++;
                if (!vld_32 || got !== held) begin n_fail++; $display("FAIL stall_stable: got %b/%h expected 1/%h", vld_32, got, held); end
            end
            n_checks++;
            if (rdy_32 !== !(vld_32 && !in_ready)) begin n_fail++; $display("FAIL ready_rule: got %b expected %b", rdy_32, !(vld_32 && !in_ready)); end
            if (vld_32 && in_ready) begin
                n_checks++;
                if (q32.size() == 0) begin n_fail++; $display("FAIL bubble_extra: got %h expected none", got); end
                else begin e = q32.pop_front(); if (got !== e) begin n_fail++; $display("FAIL bubble_result: got %h expected %h", got, e); end end
            end
            hold = vld_32 && !in_ready;
            held = got;
            if (in_valid && rdy_32) q32.push_back(model(a, b, cin, sub));
        end
        n_checks++; if (q32.size() != 0) begin n_fail++; $display("FAIL bubble_drain: got %0d pending expected 0", q32.size()); end
    endtask

    task automatic test_backpressure();
        res_t held, got, e;
        int   n_out;
        apply_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            drive(1'b1, 1'b0);
            if (in_valid && rdy_32) q32.push_back(model(a, b, cin, sub));
        end
        n_checks++; if (q32.size() != LAT) begin n_fail++; $display("FAIL bp_fill: got %0d expected %0d", q32.size(), LAT); end
        held = '{sum: sum_32, c: co_32, ovf: ovf_32};
        for (int cyc = 0; cyc < 5; cyc++) begin
            drive(1'b1, 1'b0);
            got = '{sum: sum_32, c: co_32, ovf: ovf_32};
            n_checks++; if (rdy_32 !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0", rdy_32); end
            n_checks++; if (vld_32 !== 1'b1 || got !== held) begin n_fail++; $display("FAIL bp_frozen: got %b/%h expected 1/%h", vld_32, got, held); end
        end
        n_out = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            drive(1'b0, 1'b1);
            if (vld_32) begin
                got = '{sum: sum_32, c: co_32, ovf: ovf_32};
                n_checks++; n_out++;
                if (q32.size() == 0) begin n_fail++; $display("FAIL bp_extra: got %h expected none", got); end
                else begin e = q32.pop_front(); if (got !== e) begin n_fail++; $display("FAIL bp_result: got %h expected %h", got, e); end end
            end
        end
        n_checks++; if (n_out != LAT) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", n_out, LAT); end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        for (int cyc = 0; cyc < 4; cyc++) drive(1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++; if (vld_256 !== 1'b1) begin n_fail++; $display("FAIL rst_pre_s256_valid: got %b expected 1", vld_256); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({vld_32, vld_8, vld_256} !== 3'b000) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 000", {vld_32, vld_8, vld_256}); end
        n_checks++; if ({sum_256, co_256, ovf_256} !== '0) begin n_fail++; $display("FAIL rst_async_out: got %h expected 0", {sum_256, co_256, ovf_256}); end
        n_checks++; if ({rdy_32, rdy_8, rdy_256} !== 3'b111) begin n_fail++; $display("FAIL rst_ready: got %b expected 111", {rdy_32, rdy_8, rdy_256}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            drive(1'b0, 1'b1);
            n_checks++;
            if ({vld_32, vld_8, vld_256} !== 3'b000) begin n_fail++; $display("FAIL rst_stale: got %b expected 000 at cycle %0d", {vld_32, vld_8, vld_256}, cyc); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_bubbles_random();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
